mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_if.sv | 30 +++
 rtl/mem_responder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder_if
// Purpose  : Request/strobe bundle for the instruction and data ports of
//            mem_responder. The tri-state data buses stay as module ports.
// Revision : 1.0  initial release
// ============================================================================
interface mem_responder_if #(
    parameter int WORD_SIZE = 16
);
    logic                 i_readM;
    logic                 i_writeM;
    logic [WORD_SIZE-1:0] i_address;
    logic                 i_ready;
    logic                 d_readM;
    logic                 d_writeM;
    logic [WORD_SIZE-1:0] d_address;
    logic                 d_ready;

    modport master (
        output i_readM, i_writeM, i_address, d_readM, d_writeM, d_address,
        input  i_ready, d_ready
    );

    modport slave (
        input  i_readM, i_writeM, i_address, d_readM, d_writeM, d_address,
        output i_ready, d_ready
    );
endinterface
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Dual-port fixed-latency memory model (read-only instruction
//            port, read/write data port) with a preload port and counters.
// Revision : 1.0  initial release
// ============================================================================
module mem_responder #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    mem_responder_if.slave            bus,
    inout  wire       [WORD_SIZE-1:0] i_data,
    inout  wire       [WORD_SIZE-1:0] d_data,
    input  wire logic                 ld_en,
    input  wire logic [ADDR_BITS-1:0] ld_addr,
    input  wire logic [WORD_SIZE-1:0] ld_data,
    output logic      [15:0]          num_reads,
    output logic      [15:0]          num_writes
);
    localparam int         c_DEPTH    = 2 ** ADDR_BITS;
    localparam logic [2:0] c_CNT_LOAD = 3'(LATENCY - 1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_BUSY = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [WORD_SIZE-1:0] r_mem [c_DEPTH];

    logic [1:0]           r_i_state, r_d_state;
    logic [2:0]           r_i_cnt,   r_d_cnt;
    logic [ADDR_BITS-1:0] r_i_idx,   r_d_idx;
    logic                 r_i_ready, r_d_ready;
    logic [WORD_SIZE-1:0] r_i_rdata, r_d_rdata;
    logic                 r_d_wr;
    logic [WORD_SIZE-1:0] r_d_wdata;
    logic [15:0]          r_num_reads, r_num_writes;

    logic                 w_i_accept, w_d_accept;
    logic                 w_i_fire,   w_d_fire;
    logic [WORD_SIZE-1:0] w_i_rd_val, w_d_rd_val;
    logic [1:0]           w_rd_inc;

    // The i-port is read-only, and index bits above ADDR_BITS are discarded.
    wire w_unused = &{1'b0, bus.i_writeM,
                      bus.i_address[WORD_SIZE-1:ADDR_BITS],
                      bus.d_address[WORD_SIZE-1:ADDR_BITS]};

    assign w_i_accept = bus.i_readM & ~ld_en;
    assign w_d_accept = (bus.d_readM | bus.d_writeM) & ~ld_en;
    assign w_i_fire   = (r_i_state == c_S_BUSY) && (r_i_cnt == 3'd0);
    assign w_d_fire   = (r_d_state == c_S_BUSY) && (r_d_cnt == 3'd0);

    // Same-edge forwarding: a loader write beats a d-port write, which beats the array.
    always_comb begin
        w_i_rd_val = r_mem[r_i_idx];
        if (w_d_fire && r_d_wr && (r_d_idx == r_i_idx))
            w_i_rd_val = r_d_wdata;
        if (ld_en && (ld_addr == r_i_idx))
            w_i_rd_val = ld_data;
        w_d_rd_val = r_mem[r_d_idx];
        if (ld_en && (ld_addr == r_d_idx))
            w_d_rd_val = ld_data;
    end

    // Instruction port. DONE behaves like IDLE on its exit edge, giving back-to-back accesses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_i_state <= c_S_IDLE;
            r_i_cnt   <= 3'd0;
            r_i_idx   <= '0;
            r_i_ready <= 1'b0;
            r_i_rdata <= '0;
        end else begin
            r_i_ready <= 1'b0;
            case (r_i_state)
                c_S_IDLE, c_S_DONE: begin
                    if (w_i_accept) begin
                        r_i_state <= c_S_BUSY;
                        r_i_cnt   <= c_CNT_LOAD;
                        r_i_idx   <= bus.i_address[ADDR_BITS-1:0];
                    end else begin
                        r_i_state <= c_S_IDLE;
                    end
                end
                c_S_BUSY: begin
                    if (r_i_cnt == 3'd0) begin
                        r_i_state <= c_S_DONE;
                        r_i_ready <= 1'b1;
                        r_i_rdata <= w_i_rd_val;
                    end else begin
                        r_i_cnt <= r_i_cnt - 3'd1;
                    end
                end
                default: r_i_state <= c_S_IDLE;
            endcase
        end
    end

    // Data port; a request with both read and write high is a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_d_state <= c_S_IDLE;
            r_d_cnt   <= 3'd0;
            r_d_idx   <= '0;
            r_d_ready <= 1'b0;
            r_d_rdata <= '0;
            r_d_wr    <= 1'b0;
            r_d_wdata <= '0;
        end else begin
            r_d_ready <= 1'b0;
            case (r_d_state)
                c_S_IDLE, c_S_DONE: begin
                    if (w_d_accept) begin
                        r_d_state <= c_S_BUSY;
                        r_d_cnt   <= c_CNT_LOAD;
                        r_d_idx   <= bus.d_address[ADDR_BITS-1:0];
                        r_d_wr    <= bus.d_writeM;
                        r_d_wdata <= d_data;
                    end else begin
                        r_d_state <= c_S_IDLE;
                    end
                end
                c_S_BUSY: begin
                    if (r_d_cnt == 3'd0) begin
                        r_d_state <= c_S_DONE;
                        r_d_ready <= 1'b1;
                        if (!r_d_wr)
                            r_d_rdata <= w_d_rd_val;
                    end else begin
                        r_d_cnt <= r_d_cnt - 3'd1;
                    end
                end
                default: r_d_state <= c_S_IDLE;
            endcase
        end
    end

    // Loader is written last so it wins a same-index collision with a d-port commit.
    always_ff @(posedge clk) begin
        if (w_d_fire && r_d_wr)
            r_mem[r_d_idx] <= r_d_wdata;
        if (ld_en)
            r_mem[ld_addr] <= ld_data;
    end

    assign w_rd_inc = {1'b0, w_i_fire} + {1'b0, w_d_fire & ~r_d_wr};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_num_reads  <= 16'd0;
            r_num_writes <= 16'd0;
        end else begin
            r_num_reads  <= r_num_reads + {14'd0, w_rd_inc};
            r_num_writes <= r_num_writes + {15'd0, w_d_fire & r_d_wr};
        end
    end

    assign bus.i_ready = r_i_ready;
    assign bus.d_ready = r_d_ready;
    assign num_reads   = r_num_reads;
    assign num_writes  = r_num_writes;
    assign i_data      = r_i_ready ? r_i_rdata : {WORD_SIZE{1'bz}};
    assign d_data      = (r_d_ready && !r_d_wr) ? r_d_rdata : {WORD_SIZE{1'bz}};
endmodule
`default_nettype wire
